// File: rtl/regfile_master.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_master
//  Description : Command-driven initiator for a single-port register file;
//                turns READ/WRITE/DUMP/CLEAR commands into port cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_master #(
    parameter int Bits = 8,
    parameter int Bus  = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_op,
    input  logic [Bus-1:0]  cmd_addr,
    input  logic [Bits-1:0] cmd_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [Bits-1:0] rsp_data,
    output logic [Bus-1:0]  rsp_addr,
    output logic            rsp_last,
    output logic            busy,
    output logic            rf_WE,
    output logic [Bus-1:0]  rf_A,
    output logic [Bits-1:0] rf_WD,
    input  logic [Bits-1:0] rf_RD
);

    localparam logic [1:0]   c_OP_READ  = 2'b00;
    localparam logic [1:0]   c_OP_WRITE = 2'b01;
    localparam logic [1:0]   c_OP_DUMP  = 2'b10;
    localparam logic [1:0]   c_OP_CLEAR = 2'b11;
    localparam logic [Bus:0] c_IDX_TOP  = (Bus+1)'((1 << Bus) - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_RESP  = 3'd3,
        S_CLEAR = 3'd4
    } state_t;

    state_t       r_state;
    logic [1:0]   r_op;
    logic [Bus:0] r_idx;
    logic [Bus:0] w_idx_inc;
    logic         w_idx_top;

    assign w_idx_inc = r_idx + 1'b1;
    assign w_idx_top = (r_idx == c_IDX_TOP);
    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);

    // rf_A and rf_WD double as the latched command address and write data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_op      <= c_OP_READ;
            r_idx     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_addr  <= '0;
            rsp_last  <= 1'b0;
            rf_WE     <= 1'b0;
            rf_A      <= '0;
            rf_WD     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_op  <= cmd_op;
                        r_idx <= '0;
                        case (cmd_op)
                            c_OP_READ: begin
                                r_state <= S_READ;
                                rf_A    <= cmd_addr;
                            end
                            c_OP_WRITE: begin
                                r_state <= S_WRITE;
                                rf_WE   <= 1'b1;
                                rf_A    <= cmd_addr;
                                rf_WD   <= cmd_wdata;
                            end
                            c_OP_DUMP: begin
                                r_state <= S_READ;
                                rf_A    <= '0;
                            end
                            c_OP_CLEAR: begin
                                r_state <= S_CLEAR;
                                rf_WE   <= 1'b1;
                                rf_A    <= '0;
                                rf_WD   <= '0;
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    r_state <= S_IDLE;
                    rf_WE   <= 1'b0;
                    rf_A    <= '0;
                    rf_WD   <= '0;
                end
                S_READ: begin
                    r_state   <= S_RESP;
                    rsp_valid <= 1'b1;
                    rsp_data  <= rf_RD;
                    rsp_addr  <= rf_A;
                    rsp_last  <= (r_op != c_OP_DUMP) || w_idx_top;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (rsp_last) begin
                            r_state <= S_IDLE;
                            rf_A    <= '0;
                        end else begin
                            r_state <= S_READ;
                            r_idx   <= w_idx_inc;
                            rf_A    <= w_idx_inc[Bus-1:0];
                        end
                    end
                end
                S_CLEAR: begin
                    if (w_idx_top) begin
                        r_state <= S_IDLE;
                        rf_WE   <= 1'b0;
                        rf_A    <= '0;
                    end else begin
                        r_idx <= w_idx_inc;
                        rf_A  <= w_idx_inc[Bus-1:0];
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    rf_WE   <= 1'b0;
                    rf_A    <= '0;
                    rf_WD   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_master
//  Description : Directed self-checking bench for regfile_master with a
//                behavioural 4x8 register file attached.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_master;

    localparam int Bits = 8;
    localparam int Bus  = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [Bus-1:0]  cmd_addr;
    logic [Bits-1:0] cmd_wdata;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [Bits-1:0] rsp_data;
    logic [Bus-1:0]  rsp_addr;
    logic            rsp_last;
    logic            busy;
    logic            rf_WE;
    logic [Bus-1:0]  rf_A;
    logic [Bits-1:0] rf_WD;
    logic [Bits-1:0] rf_RD;

    logic [Bits-1:0] mem     [4];
    logic [Bits-1:0] exp_mem [4];

    int n_checks = 0;
    int n_fails  = 0;

    regfile_master #(.Bits(Bits), .Bus(Bus)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_addr  (rsp_addr),
        .rsp_last  (rsp_last),
        .busy      (busy),
        .rf_WE     (rf_WE),
        .rf_A      (rf_A),
        .rf_WD     (rf_WD),
        .rf_RD     (rf_RD)
    );

    always #5 clk = ~clk;

    // Register file model: combinational read, clocked write.
    assign rf_RD = mem[rf_A];
    always @(posedge clk) begin
        if (rf_WE) mem[rf_A] <= rf_WD;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a command and returns 1ns after the edge that accepts it.
    task automatic send_cmd(input logic [1:0] op, input logic [1:0] addr, input logic [7:0] wdata);
        int waited;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        waited    = 0;
        while (!cmd_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (waited >= 50) check("cmd_accept_timeout", 32'd0, 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic do_write(input logic [1:0] addr, input logic [7:0] wdata);
        send_cmd(2'b01, addr, wdata);
        tick();
    endtask

    task automatic wait_rsp();
        int waited;
        waited = 0;
        while (!rsp_valid && waited < 50) begin
            tick();
            waited++;
        end
        if (waited >= 50) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    // Collects n dump responses, stalling one cycle on each before accepting.
    task automatic collect_dump(input int n);
        for (int i = 0; i < n; i++) begin
            wait_rsp();
            check("dump_data", 32'(rsp_data), 32'(exp_mem[i]));
            check("dump_addr", 32'(rsp_addr), 32'(i));
            check("dump_last", 32'(rsp_last), (i == 3) ? 32'd1 : 32'd0);
            tick();
            check("dump_stall_valid", 32'(rsp_valid), 32'd1);
            check("dump_stall_data", 32'(rsp_data), 32'(exp_mem[i]));
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            check("dump_valid_drop", 32'(rsp_valid), 32'd0);
        end
    endtask

    initial begin
        int seen;
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) mem[i] = 8'h00;

        repeat (2) tick();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rf_we", 32'(rf_WE), 32'd0);
        check("rst_rf_a", 32'(rf_A), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        reset = 1'b1;
        tick();

        // WRITE addr 2 <- A5
        send_cmd(2'b01, 2'd2, 8'hA5);
        check("wr_we", 32'(rf_WE), 32'd1);
        check("wr_a", 32'(rf_A), 32'd2);
        check("wr_wd", 32'(rf_WD), 32'hA5);
        check("wr_ready_busy", 32'(cmd_ready), 32'd0);
        tick();
        check("wr_we_off", 32'(rf_WE), 32'd0);
        check("wr_ready_back", 32'(cmd_ready), 32'd1);
        check("wr_mem", 32'(mem[2]), 32'hA5);

        // WRITE 3 <- 3C, READ 3 with rsp_ready held high
        do_write(2'd3, 8'h3C);
        rsp_ready = 1'b1;
        send_cmd(2'b00, 2'd3, 8'h00);
        check("rd_valid_early", 32'(rsp_valid), 32'd0);
        check("rd_rf_a", 32'(rf_A), 32'd3);
        tick();
        check("rd_valid", 32'(rsp_valid), 32'd1);
        check("rd_data", 32'(rsp_data), 32'h3C);
        check("rd_addr", 32'(rsp_addr), 32'd3);
        check("rd_last", 32'(rsp_last), 32'd1);
        tick();
        rsp_ready = 1'b0;
        check("rd_valid_drop", 32'(rsp_valid), 32'd0);
        check("rd_ready_back", 32'(cmd_ready), 32'd1);

        // Preload and DUMP with stalls
        do_write(2'd0, 8'h11);
        do_write(2'd1, 8'h22);
        do_write(2'd2, 8'h33);
        do_write(2'd3, 8'h44);
        exp_mem[0] = 8'h11; exp_mem[1] = 8'h22; exp_mem[2] = 8'h33; exp_mem[3] = 8'h44;
        send_cmd(2'b10, 2'd3, 8'h00);
        collect_dump(4);
        tick();
        check("dump_done_ready", 32'(cmd_ready), 32'd1);

        // CLEAR then DUMP of zeros
        send_cmd(2'b11, 2'd1, 8'hFF);
        for (int i = 0; i < 4; i++) begin
            check("clr_we", 32'(rf_WE), 32'd1);
            check("clr_a", 32'(rf_A), 32'(i));
            check("clr_wd", 32'(rf_WD), 32'd0);
            tick();
        end
        check("clr_we_off", 32'(rf_WE), 32'd0);
        check("clr_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 4; i++) exp_mem[i] = 8'h00;
        send_cmd(2'b10, 2'd0, 8'h00);
        collect_dump(4);

        // WRITE held off while a READ response is stalled
        do_write(2'd1, 8'h5A);
        send_cmd(2'b00, 2'd1, 8'h00);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_addr  = 2'd0;
        cmd_wdata = 8'h77;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("stall_ready", 32'(cmd_ready), 32'd0);
            check("stall_we", 32'(rf_WE), 32'd0);
            check("stall_valid", 32'(rsp_valid), 32'd1);
            tick();
        end
        check("stall_data", 32'(rsp_data), 32'h5A);
        check("stall_mem0", 32'(mem[0]), 32'h00);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("held_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        check("held_we", 32'(rf_WE), 32'd1);
        check("held_a", 32'(rf_A), 32'd0);
        check("held_wd", 32'(rf_WD), 32'h77);
        tick();
        check("held_mem0", 32'(mem[0]), 32'h77);

        // Reset in the middle of a DUMP after two responses
        do_write(2'd0, 8'h11);
        do_write(2'd1, 8'h22);
        exp_mem[0] = 8'h11; exp_mem[1] = 8'h22;
        send_cmd(2'b10, 2'd0, 8'h00);
        collect_dump(2);
        wait_rsp();
        reset = 1'b0;
        #2;
        check("arst_valid", 32'(rsp_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_ready", 32'(cmd_ready), 32'd1);
        check("arst_rf_a", 32'(rf_A), 32'd0);
        check("arst_rsp_data", 32'(rsp_data), 32'd0);
        check("arst_rsp_addr", 32'(rsp_addr), 32'd0);
        rsp_ready = 1'b1;
        tick();
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rsp_valid) seen++;
        end
        rsp_ready = 1'b0;
        check("arst_no_rsp", 32'(seen), 32'd0);
        check("arst_ready_after", 32'(cmd_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
